// File: rtl/ms_c2_serial_converter.sv
// rtl/ms_c2_serial_converter.sv - bit-serial sign-magnitude <-> two's complement converter, LSB first
// Define MS_C2_SAT_EN to saturate z on MS->C2 overflow instead of wrapping.
module ms_c2_serial_converter #(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         start,
   input  logic         mode,
   input  logic [N-1:0] x,
   input  logic         sgn_in,
   output logic         rfd,
   output logic         done,
   output logic [N-1:0] z,
   output logic         sgn_out,
   output logic         ow
);
   localparam int             CW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0]   MIN_MAG = {1'b1, {(N-1){1'b0}}};
   localparam logic [CW-1:0]  LAST    = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  shreg_q, shreg_d;
   logic [N-1:0]  res_q, res_d;
   logic [N-1:0]  z_q, z_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic          seen_q, seen_d;
   logic          ovf_q, ovf_d;
   logic          rfd_q, rfd_d;
   logic          done_q, done_d;
   logic          sgn_q, sgn_d;
   logic          ow_q, ow_d;
   logic          bit_in;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      res_d   = res_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      seen_d  = seen_q;
      ovf_d   = ovf_q;
      sgn_d   = sgn_q;
      ow_d    = ow_q;
      done_d  = 1'b0;
      bit_in  = shreg_q[0];
      case (state_q)
         IDLE: begin
            if (start) begin
               shreg_d = x;
               neg_d   = mode ? x[N-1] : sgn_in;
               seen_d  = 1'b0;
               cnt_d   = '0;
               // Only -2^(N-1) fits when the magnitude MSB is set.
               ovf_d   = ~mode & x[N-1] & ~(sgn_in & (x == MIN_MAG));
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            res_d   = {(neg_q ? (bit_in ^ seen_q) : bit_in), res_q[N-1:1]};
            seen_d  = seen_q | bit_in;
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = DONE;
         end
         DONE: begin
            z_d = res_q;
`ifdef MS_C2_SAT_EN
            if (ovf_q) z_d = neg_q ? MIN_MAG : ~MIN_MAG;
`endif
            sgn_d   = neg_q;
            ow_d    = ovf_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rfd_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         shreg_q <= '0;
         res_q   <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         seen_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rfd_q   <= 1'b1;
         done_q  <= 1'b0;
         sgn_q   <= 1'b0;
         ow_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         res_q   <= res_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         seen_q  <= seen_d;
         ovf_q   <= ovf_d;
         rfd_q   <= rfd_d;
         done_q  <= done_d;
         sgn_q   <= sgn_d;
         ow_q    <= ow_d;
      end
   end

   assign rfd     = rfd_q;
   assign done    = done_q;
   assign z       = z_q;
   assign sgn_out = sgn_q;
   assign ow      = ow_q;
endmodule

// File: tb/tb_ms_c2_serial_converter.sv
// tb/tb_ms_c2_serial_converter.sv - randomized self-checking bench with arithmetic reference model
module tb_ms_c2_serial_converter;
   localparam int N = 8;
`ifdef MS_C2_SAT_EN
   localparam logic [7:0] SATZ = 8'h7F;
`else
   localparam logic [7:0] SATZ = 8'h80;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_, start, mode, sgn_in;
   logic [7:0]  x;
   logic        rfd, done, sgn_out, ow;
   logic [7:0]  z;
   logic        start16, mode16, sgn16;
   logic [15:0] x16, z16;
   logic        rfd16, done16, sgn16_out, ow16;

   ms_c2_serial_converter #(.N(8)) dut8 (
      .clock(clock), .reset_(reset_), .start(start), .mode(mode), .x(x), .sgn_in(sgn_in),
      .rfd(rfd), .done(done), .z(z), .sgn_out(sgn_out), .ow(ow)
   );

   ms_c2_serial_converter #(.N(16)) dut16 (
      .clock(clock), .reset_(reset_), .start(start16), .mode(mode16), .x(x16), .sgn_in(sgn16),
      .rfd(rfd16), .done(done16), .z(z16), .sgn_out(sgn16_out), .ow(ow16)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void ref8(input logic m, input logic [7:0] xv, input logic s,
                                output logic [7:0] rz, output logic rs, output logic row);
      int v;
      if (!m) begin
         v   = s ? -int'(xv) : int'(xv);
         row = (xv >= 8'd128) && !(s && xv == 8'd128);
         rz  = 8'(v);
         rs  = s;
`ifdef MS_C2_SAT_EN
         if (row) rz = s ? 8'h80 : 8'h7F;
`endif
      end else begin
         v   = int'($signed(xv));
         rs  = (v < 0);
         rz  = 8'((v < 0) ? -v : v);
         row = 1'b0;
      end
   endfunction

   int         m_left = 0;
   logic       m_done = 1'b0;
   logic [7:0] m_z = 8'h00, p_z = 8'h00, tz;
   logic       m_s = 1'b0, m_ow = 1'b0, p_s = 1'b0, p_ow = 1'b0, ts, tow;

   always @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_z    <= 8'h00;
         m_s    <= 1'b0;
         m_ow   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_left == 0) begin
            if (start) begin
               ref8(mode, x, sgn_in, tz, ts, tow);
               p_z    <= tz;
               p_s    <= ts;
               p_ow   <= tow;
               m_left <= N + 1;
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_z    <= p_z;
               m_s    <= p_s;
               m_ow   <= p_ow;
               m_done <= 1'b1;
            end
         end
      end
   end

   bit cmp_en = 1'b0;
   always @(negedge clock) begin
      if (cmp_en) begin
         check("cyc_rfd", rfd, m_left == 0);
         check("cyc_done", done, m_done);
         check("cyc_z", z, m_z);
         check("cyc_sgn", sgn_out, m_s);
         check("cyc_ow", ow, m_ow);
      end
   end

   task automatic run8(input logic m, input logic [7:0] xv, input logic s, input logic [7:0] ez,
                       input logic es, input logic eow, input string nm);
      int lows, cyc;
      check({nm, "_rfd_idle"}, rfd, 1);
      start = 1'b1; mode = m; x = xv; sgn_in = s;
      @(negedge clock);
      start = 1'b0; x = 8'($urandom); mode = ~m; sgn_in = ~s;
      lows = 0; cyc = 0;
      while (!done && cyc < 40) begin
         if (!rfd) lows++;
         @(negedge clock);
         cyc++;
      end
      check({nm, "_done"}, done, 1);
      check({nm, "_rfdlow"}, lows, N + 1);
      check({nm, "_z"}, z, ez);
      check({nm, "_sgn"}, sgn_out, es);
      check({nm, "_ow"}, ow, eow);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rz8;
      logic       rs8, row8;
      int         d1, d2, k, ndone;
      logic [7:0] z1, z2;

      ref8(1'b0, 8'h05, 1'b1, rz8, rs8, row8);
      check("model_neg5", {rz8, rs8, row8}, {8'hFB, 1'b1, 1'b0});
      ref8(1'b1, 8'hFF, 1'b0, rz8, rs8, row8);
      check("model_c2m1", {rz8, rs8, row8}, {8'h01, 1'b1, 1'b0});
      ref8(1'b0, 8'h90, 1'b1, rz8, rs8, row8);
`ifdef MS_C2_SAT_EN
      check("model_ovf", {rz8, rs8, row8}, {8'h80, 1'b1, 1'b1});
`else
      check("model_ovf", {rz8, rs8, row8}, {8'h70, 1'b1, 1'b1});
`endif

      reset_ = 1'b0; start = 1'b0; mode = 1'b0; sgn_in = 1'b0; x = 8'h00;
      start16 = 1'b0; mode16 = 1'b0; sgn16 = 1'b0; x16 = 16'h0000;
      repeat (3) @(negedge clock);
      check("rst_rfd", rfd, 1);
      check("rst_done", done, 0);
      check("rst_z", z, 0);
      check("rst_sgn", sgn_out, 0);
      check("rst_ow", ow, 0);
      reset_ = 1'b1;
      cmp_en = 1'b1;
      @(negedge clock);

      run8(1'b0, 8'h05, 1'b1, 8'hFB, 1'b1, 1'b0, "ms_neg5");
      run8(1'b0, 8'h80, 1'b1, 8'h80, 1'b1, 1'b0, "ms_min");
      run8(1'b0, 8'h80, 1'b0, SATZ,  1'b0, 1'b1, "ms_ovf");
      run8(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ms_negzero");
      run8(1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0, "c2_m1");
      run8(1'b1, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0, "c2_min");
      run8(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "c2_zero");

      // Ignored mid-SHIFT start, then start held from DONE into IDLE.
      d1 = -1; d2 = -1; z1 = 8'h00; z2 = 8'h00;
      start = 1'b1; mode = 1'b0; x = 8'h05; sgn_in = 1'b1;
      for (k = 1; k <= 24; k++) begin
         @(negedge clock);
         if (done) begin
            if (d1 < 0) begin d1 = k; z1 = z; end
            else if (d2 < 0) begin d2 = k; z2 = z; end
         end
         case (k)
            1: begin start = 1'b0; x = 8'($urandom); end
            3: begin start = 1'b1; x = 8'h7F; end
            4: start = 1'b0;
            N + 1: begin start = 1'b1; x = 8'h03; sgn_in = 1'b0; mode = 1'b0; end
            N + 3: start = 1'b0;
            default: ;
         endcase
      end
      check("ovl_d1", d1, N + 2);
      check("ovl_z1", z1, 8'hFB);
      check("ovl_d2", d2, 2 * N + 4);
      check("ovl_z2", z2, 8'h03);

      start = 1'b1; mode = 1'b0; x = 8'h37; sgn_in = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (2) @(negedge clock);
      #2 reset_ = 1'b0;
      #1;
      check("arst_rfd", rfd, 1);
      check("arst_done", done, 0);
      check("arst_z", z, 0);
      check("arst_ow", ow, 0);
      check("arst_sgn", sgn_out, 0);
      @(negedge clock);
      reset_ = 1'b1;
      @(negedge clock);
      run8(1'b0, 8'h37, 1'b1, 8'hC9, 1'b1, 1'b0, "post_rst");

      start16 = 1'b1; mode16 = 1'b0; x16 = 16'h1234; sgn16 = 1'b1;
      @(negedge clock);
      start16 = 1'b0; x16 = 16'($urandom);
      k = 1;
      while (!done16 && k < 60) begin
         @(negedge clock);
         k++;
      end
      check("n16_edges", k - 1, 17);
      check("n16_z", z16, 16'hEDCC);
      check("n16_sgn", sgn16_out, 1);
      check("n16_ow", ow16, 0);

      ndone = 0;
      for (int c = 0; c < 3000; c++) begin
         int r;
         start  = (($urandom % 4) == 0);
         mode   = 1'($urandom);
         sgn_in = 1'($urandom);
         r = int'($urandom % 8);
         case (r)
            0: x = 8'h80;
            1: x = 8'h00;
            2: x = 8'hFF;
            3: x = 8'h7F;
            default: x = 8'($urandom);
         endcase
         @(negedge clock);
         if (done) ndone++;
      end
      start = 1'b0;
      check("rand_activity", ndone > 50, 1);
      repeat (12) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
